// File: rtl/ps2_mouse_packet_pkg.sv
// ps2_mouse_packet_pkg: shared flag values and PS/2 mouse byte0 bit positions
package ps2_mouse_packet_pkg;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XO    = 6;
    localparam int YO    = 7;
endpackage

// File: rtl/ps2_delta_to_signmag.sv
// ps2_delta_to_signmag: 9-bit two's-complement movement plus overflow to saturated sign-magnitude
module ps2_delta_to_signmag (
    input  logic [8:0] raw,
    input  logic       ovf,
    output logic [8:0] sm
);
    logic [8:0] neg;
    logic [7:0] mag;
    always_comb begin
        neg = ~raw + 9'd1;
        mag = ovf ? 8'hFF : !raw[8] ? raw[7:0] : neg[8] ? 8'hFF : neg[7:0];
        sm  = {raw[8] && mag != 8'd0, mag};
    end
endmodule

// File: rtl/ps2_mouse_packet.sv
// ps2_mouse_packet: assembles 3-byte PS/2 mouse packets and holds them behind a data_ready/read handshake
module ps2_mouse_packet
    import ps2_mouse_packet_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int TIMEOUT_WIDTH  = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_error,
    input  logic       read,
    output logic       data_ready,
    output logic       left_button,
    output logic       middle_button,
    output logic       right_button,
    output logic [8:0] x_increment,
    output logic [8:0] y_increment,
    output logic       sync_error,
    output logic       packet_dropped
);
    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;
    state_t state, state_n;
    logic [TIMEOUT_WIDTH-1:0] cnt, cnt_n;
    logic [2:0] btn;
    logic xs, ys, xo, yo;
    logic [7:0] b1;
    logic b0_en, b1_en, load, sync_n, timeout;
    logic [8:0] x_sm, y_sm;

    ps2_delta_to_signmag u_x (.raw({xs, b1}), .ovf(xo), .sm(x_sm));
    ps2_delta_to_signmag u_y (.raw({ys, byte_in}), .ovf(yo), .sm(y_sm));

    assign timeout = state != WAIT_B0 && cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    // timeout wins over a byte in the same cycle; that byte is dropped
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sync_n  = FALSE;
        b0_en   = FALSE;
        b1_en   = FALSE;
        load    = FALSE;
        if (timeout) begin
            state_n = WAIT_B0;
            sync_n  = TRUE;
            cnt_n   = '0;
        end else if (byte_valid) begin
            cnt_n = '0;
            if (state == WAIT_B0) begin
                if (!byte_error && byte_in[SYNC]) begin
                    state_n = WAIT_B1;
                    b0_en   = TRUE;
                end else begin
                    sync_n = TRUE;
                end
            end else if (byte_error) begin
                state_n = WAIT_B0;
                sync_n  = TRUE;
            end else if (state == WAIT_B1) begin
                state_n = WAIT_B2;
                b1_en   = TRUE;
            end else begin
                state_n = WAIT_B0;
                load    = TRUE;
            end
        end else if (state != WAIT_B0) begin
            cnt_n = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= WAIT_B0;
            cnt            <= '0;
            btn            <= '0;
            {xs, ys, xo, yo} <= '0;
            b1             <= '0;
            data_ready     <= 1'b0;
            left_button    <= 1'b0;
            middle_button  <= 1'b0;
            right_button   <= 1'b0;
            x_increment    <= '0;
            y_increment    <= '0;
            sync_error     <= 1'b0;
            packet_dropped <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            sync_error     <= sync_n;
            packet_dropped <= load && data_ready && !read;
            if (b0_en) begin
                btn              <= {byte_in[BTN_M], byte_in[BTN_R], byte_in[BTN_L]};
                {xs, ys, xo, yo} <= {byte_in[XS], byte_in[YS], byte_in[XO], byte_in[YO]};
            end
            if (b1_en)
                b1 <= byte_in;
            if (load) begin
                data_ready    <= 1'b1;
                left_button   <= btn[0];
                right_button  <= btn[1];
                middle_button <= btn[2];
                x_increment   <= x_sm;
                y_increment   <= y_sm;
            end else if (read) begin
                data_ready <= 1'b0;
            end
        end
    end
endmodule
